accum_div: RTL

- Sequential restoring divider. It is the inverse companion of the accum5 add/subtract accumulator.
- Takes an N-bit dividend and divisor. Produces quotient and remainder by one shift-subtract step per clock.
- Sits beside accum5 in the Exer datapath and reports status flags in the same style as accum5's overflow (of).
- Uses a start/busy/done handshake so a controller or testbench can issue back-to-back operations.

---
 rtl/accum_div.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/accum_div.sv
// accum_div: sequential restoring divider, the inverse companion of the
// accum5 add/subtract accumulator. Each accepted request takes one
// shift-subtract step per clock and produces a quotient and a remainder.
//
// Optional build macro: ACCDIV_SIGNED_EN
//   Undefined (default): unsigned operands only, no sgn port, of tied to 0.
//   Defined: adds input sgn. With sgn=1 the operands are two's complement.
//   The core divides magnitudes, and the sign fix-up is folded into the
//   load of the results, so latency does not change.
//
// Ports
//   Clk          in   rising-edge clock
//   Reset        in   synchronous, active-high reset
//   start        in   request pulse, accepted only in IDLE or DONE
//   dividend     in   N-bit numerator, captured on an accepted start
//   divisor      in   N-bit denominator, captured on an accepted start
//   sgn          in   signed-mode select (ACCDIV_SIGNED_EN builds only)
//   quot         out  quotient; updated on entry to DONE, then held
//   rem          out  remainder; updated on entry to DONE, then held
//   busy         out  high in RUN and ZERO
//   done         out  one-cycle completion pulse (DONE state)
//   dbz          out  divide-by-zero flag, cleared on an accepted start
//   of           out  signed overflow flag (-2^(N-1) / -1)
//   dbg_state_o  out  current FSM state, for checkers
//
// Handshake: start is honoured only when busy=0 (IDLE or DONE). A start
// seen in DONE is accepted back-to-back. A start seen while busy=1 is
// ignored. Results are valid while done=1 and are held until the next
// completion.
module accum_div #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
`ifdef ACCDIV_SIGNED_EN
  input  logic         sgn,
`endif
  output logic [N-1:0] quot,
  output logic [N-1:0] rem,
  output logic         busy,
  output logic         done,
  output logic         dbz,
  output logic         of,
  output logic [1:0]   dbg_state_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_ZERO = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);
  localparam logic [N-1:0]  MIN_NEG  = {1'b1, {(N-1){1'b0}}};

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [N-1:0]  dvd_q,   dvd_d;   // dividend magnitude, shifted out MSB first
  logic [N-1:0]  dvs_q,   dvs_d;   // divisor magnitude
  logic [N-1:0]  p_q,     p_d;     // partial remainder
  logic [N-1:0]  qacc_q,  qacc_d;  // quotient bits collected so far
  logic          negq_q,  negq_d;  // negate the quotient at the end
  logic          negr_q,  negr_d;  // negate the remainder at the end
  logic [N-1:0]  quot_q,  quot_d;
  logic [N-1:0]  rem_q,   rem_d;
  logic          dbz_q,   dbz_d;

  logic sgn_w;
`ifdef ACCDIV_SIGNED_EN
  assign sgn_w = sgn;
`else
  assign sgn_w = 1'b0;
`endif

  // Operand magnitudes. Unary minus keeps the N-bit width, so -(-2^(N-1))
  // comes out as the unsigned value 2^(N-1). That is the magnitude we want.
  logic         a_neg, b_neg, div_zero, accept;
  logic [N-1:0] a_mag, b_mag;
  assign a_neg    = sgn_w & dividend[N-1];
  assign b_neg    = sgn_w & divisor[N-1];
  assign a_mag    = a_neg ? -dividend : dividend;
  assign b_mag    = b_neg ? -divisor  : divisor;
  assign div_zero = (divisor == '0);
  assign accept   = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));

  // One restoring step. The shifted remainder needs N+1 bits. The borrow
  // (MSB) of the N+1-bit difference is set exactly when p_sh < divisor,
  // because p_sh < 2*divisor always holds here.
  logic [N:0]   p_sh, diff;
  logic         q_bit;
  logic [N-1:0] p_new, q_new, q_fix, r_fix;
  assign p_sh  = {p_q, dvd_q[N-1]};
  assign diff  = p_sh - {1'b0, dvs_q};
  assign q_bit = ~diff[N];
  assign p_new = q_bit ? diff[N-1:0] : p_sh[N-1:0];
  assign q_new = {qacc_q[N-2:0], q_bit};
  assign q_fix = negq_q ? -q_new : q_new;
  assign r_fix = negr_q ? -p_new : p_new;

`ifdef ACCDIV_SIGNED_EN
  logic ofp_q, ofp_d;  // overflow case detected at accept, shown at DONE
  logic of_q,  of_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    p_d     = p_q;
    qacc_d  = qacc_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef ACCDIV_SIGNED_EN
    ofp_d   = ofp_q;
    of_d    = of_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          dvs_d  = b_mag;
          p_d    = '0;
          qacc_d = '0;
          cnt_d  = CNT_INIT;
          negq_d = a_neg ^ b_neg;
          negr_d = a_neg;
          dbz_d  = 1'b0;
`ifdef ACCDIV_SIGNED_EN
          ofp_d  = sgn_w & (dividend == MIN_NEG) & (divisor == {N{1'b1}});
          of_d   = 1'b0;
`endif
          if (div_zero) begin
            // ZERO reports the raw dividend as the remainder.
            dvd_d   = dividend;
            state_d = ST_ZERO;
          end else begin
            dvd_d   = a_mag;
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        p_d    = p_new;
        qacc_d = q_new;
        dvd_d  = {dvd_q[N-2:0], 1'b0};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          quot_d  = q_fix;
          rem_d   = r_fix;
`ifdef ACCDIV_SIGNED_EN
          of_d    = ofp_q;
`endif
          state_d = ST_DONE;
        end
      end
      ST_ZERO: begin
        quot_d  = '1;
        rem_d   = dvd_q;
        dbz_d   = 1'b1;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      p_q     <= '0;
      qacc_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef ACCDIV_SIGNED_EN
      ofp_q   <= 1'b0;
      of_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      p_q     <= p_d;
      qacc_q  <= qacc_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef ACCDIV_SIGNED_EN
      ofp_q   <= ofp_d;
      of_q    <= of_d;
`endif
    end
  end

  assign quot        = quot_q;
  assign rem         = rem_q;
  assign dbz         = dbz_q;
  assign busy        = (state_q == ST_RUN) | (state_q == ST_ZERO);
  assign done        = (state_q == ST_DONE);
  assign dbg_state_o = state_q;
`ifdef ACCDIV_SIGNED_EN
  assign of          = of_q;
`else
  assign of          = 1'b0;
`endif

endmodule
